ad7264_spi_responder: RTL and testbench



---
 rtl/ad7264_spi_responder_pkg.sv | 21 ++
 rtl/ad7264_spi_responder_edge_sync.sv | 65 ++++++
 rtl/ad7264_spi_responder.sv | 177 +++++++++++++++++
 tb/tb_ad7264_spi_responder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ad7264_spi_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ad7264_spi_responder_pkg
// Description : Shared widths, frame geometry defaults and FSM state encoding
//               for the AD7264 SPI responder.
// Revision    : 1.0 - initial release
// ============================================================================
package ad7264_spi_responder_pkg;

    localparam int AD7264_SAMPLE_W    = 14;
    localparam int AD7264_CTRL_W      = 16;
    localparam int AD7264_FRAME_BITS  = 32;
    localparam int AD7264_DATA_START  = 18;

    // Responder FSM encoding
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/ad7264_spi_responder_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : spi_edge_sync
// Description : Brings SCLK, SS and MOSI into the clk domain through 2-flop
//               synchronizers and derives single-clk edge pulses.
// Ports       : clk, resetn        - system clock, async active-low reset
//               sclk, ss_n, mosi   - raw SPI pins
//               ss_n_sync          - synchronized slave select
//               mosi_sync          - synchronized MOSI, aligned with sclk pulses
//               sample_pulse       - SCLK edge on which MOSI is captured
//               drive_pulse        - SCLK edge on which MISO advances
//               ss_fall, ss_rise   - synchronized SS edges
// Revision    : 1.0 - initial release
// ============================================================================
module spi_edge_sync #(
    parameter bit CPOL = 1'b1,
    parameter bit CPHA = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic sclk,
    input  logic ss_n,
    input  logic mosi,
    output logic ss_n_sync,
    output logic mosi_sync,
    output logic sample_pulse,
    output logic drive_pulse,
    output logic ss_fall,
    output logic ss_rise
);

    logic [2:0] r_sclk;
    logic [2:0] r_ss;
    logic [1:0] r_mosi;
    logic       w_lead;
    logic       w_trail;

    // SCLK history resets to its idle level so no edge is invented at reset
    // release. SS history resets low: if SS is still asserted when reset
    // lifts, no fall is seen and the responder will not join a frame halfway.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sclk <= {3{CPOL}};
            r_ss   <= 3'b000;
            r_mosi <= 2'b00;
        end else begin
            r_sclk <= {r_sclk[1:0], sclk};
            r_ss   <= {r_ss[1:0], ss_n};
            r_mosi <= {r_mosi[0], mosi};
        end
    end

    assign w_lead  = (r_sclk[2] == CPOL) && (r_sclk[1] != CPOL);
    assign w_trail = (r_sclk[2] != CPOL) && (r_sclk[1] == CPOL);

    assign sample_pulse = CPHA ? w_trail : w_lead;
    assign drive_pulse  = CPHA ? w_lead  : w_trail;

    assign ss_n_sync = r_ss[1];
    assign ss_fall   = r_ss[2] & ~r_ss[1];
    assign ss_rise   = ~r_ss[2] & r_ss[1];
    assign mosi_sync = r_mosi[1];

endmodule
`default_nettype wire

// File: rtl/ad7264_spi_responder.sv
`default_nettype none
// ============================================================================
// Module      : ad7264_spi_responder
// Description : Slave-side model of one AD7264 dual ADC. Captures the control
//               word from MOSI and returns two samples on MISO_A/MISO_B.
// Ports       : clk, resetn            - system clock (>= 4x SCLK), async reset
//               SCLK, SS, MOSI         - SPI from master (SS active low)
//               MISO_A, MISO_B         - serial results, miso_oe while driven
//               sampleA, sampleB       - parallel sample sources
//               ctrl_word, ctrl_valid  - last control word and update pulse
//               frame_done             - pulse after FRAME_BITS sample edges
//               frame_error            - pulse on SS release mid-frame
//               busy                   - high from SS fall until back in IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module ad7264_spi_responder
    import ad7264_spi_responder_pkg::*;
#(
    parameter bit CPOL       = 1'b1,
    parameter bit CPHA       = 1'b0,
    parameter int FRAME_BITS = AD7264_FRAME_BITS,
    parameter int CTRL_BITS  = AD7264_CTRL_W,
    parameter int DATA_START = AD7264_DATA_START
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       SCLK,
    input  logic                       SS,
    input  logic                       MOSI,
    output logic                       MISO_A,
    output logic                       MISO_B,
    output logic                       miso_oe,
    input  logic [AD7264_SAMPLE_W-1:0] sampleA,
    input  logic [AD7264_SAMPLE_W-1:0] sampleB,
    output logic [AD7264_CTRL_W-1:0]   ctrl_word,
    output logic                       ctrl_valid,
    output logic                       frame_done,
    output logic                       frame_error,
    output logic                       busy
);

    localparam int         c_TAIL       = FRAME_BITS - DATA_START - AD7264_SAMPLE_W;
    localparam logic [5:0] c_CTRL_END   = 6'(CTRL_BITS);
    localparam logic [5:0] c_CTRL_LAST  = 6'(CTRL_BITS - 1);
    localparam logic [5:0] c_FRAME_LAST = 6'(FRAME_BITS - 1);
    localparam logic [5:0] c_FRAME_END  = 6'(FRAME_BITS);

    logic                     w_ssSync;
    logic                     w_mosi;
    logic                     w_samplePulse;
    logic                     w_drivePulse;
    logic                     w_ssFall;
    logic                     w_ssRise;
    logic [FRAME_BITS-1:0]    w_loadA;
    logic [FRAME_BITS-1:0]    w_loadB;

    logic [1:0]               r_state;
    logic [5:0]               r_bitCnt;
    logic [CTRL_BITS-1:0]     r_ctrlShift;
    logic [AD7264_CTRL_W-1:0] r_ctrlWord;
    logic                     r_ctrlValid;
    logic                     r_frameDone;
    logic                     r_frameError;
    logic [FRAME_BITS-1:0]    r_shA;
    logic [FRAME_BITS-1:0]    r_shB;
    logic                     r_holdFirst;

    spi_edge_sync #(
        .CPOL (CPOL),
        .CPHA (CPHA)
    ) u_edgeSync (
        .clk          (clk),
        .resetn       (resetn),
        .sclk         (SCLK),
        .ss_n         (SS),
        .mosi         (MOSI),
        .ss_n_sync    (w_ssSync),
        .mosi_sync    (w_mosi),
        .sample_pulse (w_samplePulse),
        .drive_pulse  (w_drivePulse),
        .ss_fall      (w_ssFall),
        .ss_rise      (w_ssRise)
    );

    // Frame image: DATA_START leading zeros, the sample, then trailing zeros.
    // The shift registers themselves are the capture point, so a sample that
    // changes after SS fall cannot reach the current frame.
    assign w_loadA = FRAME_BITS'(sampleA) << c_TAIL;
    assign w_loadB = FRAME_BITS'(sampleB) << c_TAIL;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= c_IDLE;
            r_bitCnt     <= 6'd0;
            r_ctrlShift  <= '0;
            r_ctrlWord   <= '0;
            r_ctrlValid  <= 1'b0;
            r_frameDone  <= 1'b0;
            r_frameError <= 1'b0;
            r_shA        <= '0;
            r_shB        <= '0;
            r_holdFirst  <= 1'b0;
        end else begin
            r_ctrlValid  <= 1'b0;
            r_frameDone  <= 1'b0;
            r_frameError <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_bitCnt <= 6'd0;
                    // Any SCLK edge coincident with the SS fall is dropped here.
                    if (w_ssFall) begin
                        r_shA       <= w_loadA;
                        r_shB       <= w_loadB;
                        r_ctrlShift <= '0;
                        // With CPHA=1 the first drive edge presents bit 0,
                        // which is already at the MSB, so it must not shift.
                        r_holdFirst <= CPHA;
                        r_state     <= c_SHIFT;
                    end
                end
                c_SHIFT: begin
                    if (w_ssRise) begin
                        r_frameError <= 1'b1;
                        r_bitCnt     <= 6'd0;
                        r_state      <= c_IDLE;
                    end else begin
                        if (w_samplePulse) begin
                            if (r_bitCnt < c_CTRL_END) begin
                                r_ctrlShift <= {r_ctrlShift[CTRL_BITS-2:0], w_mosi};
                            end
                            if (r_bitCnt == c_CTRL_LAST) begin
                                r_ctrlWord  <= AD7264_CTRL_W'({r_ctrlShift[CTRL_BITS-2:0], w_mosi});
                                r_ctrlValid <= 1'b1;
                            end
                            if (r_bitCnt == c_FRAME_LAST) begin
                                r_frameDone <= 1'b1;
                                r_state     <= c_DONE;
                            end
                            if (r_bitCnt != c_FRAME_END) begin
                                r_bitCnt <= r_bitCnt + 6'd1;
                            end
                        end
                        if (w_drivePulse) begin
                            if (r_holdFirst) begin
                                r_holdFirst <= 1'b0;
                            end else begin
                                r_shA <= {r_shA[FRAME_BITS-2:0], 1'b0};
                                r_shB <= {r_shB[FRAME_BITS-2:0], 1'b0};
                            end
                        end
                    end
                end
                c_DONE: begin
                    // Level test rather than edge so a release is never missed.
                    if (w_ssSync) begin
                        r_bitCnt <= 6'd0;
                        r_state  <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign miso_oe     = (r_state == c_SHIFT);
    assign MISO_A      = miso_oe & r_shA[FRAME_BITS-1];
    assign MISO_B      = miso_oe & r_shB[FRAME_BITS-1];
    assign busy        = (r_state != c_IDLE);
    assign ctrl_word   = r_ctrlWord;
    assign ctrl_valid  = r_ctrlValid;
    assign frame_done  = r_frameDone;
    assign frame_error = r_frameError;

endmodule
`default_nettype wire

// File: tb/tb_ad7264_spi_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ad7264_spi_responder
// Description : Directed bench for ad7264_spi_responder. Instance dut0 runs
//               CPOL=1/CPHA=0, dut1 runs CPOL=0/CPHA=1; a bench-side SPI
//               master drives whichever instance is selected.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ad7264_spi_responder;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        mosi = 1'b0;
    logic [13:0] sampleA = '0;
    logic [13:0] sampleB = '0;

    logic        sclk0 = 1'b1, ss0 = 1'b1;
    logic        misoA0, misoB0, oe0, cv0, fd0, fe0, busy0;
    logic [15:0] cw0;
    logic        sclk1 = 1'b0, ss1 = 1'b1;
    logic        misoA1, misoB1, oe1, cv1, fd1, fe1, busy1;
    logic [15:0] cw1;

    int nChecks = 0;
    int nFail   = 0;
    int nCv0 = 0, nFd0 = 0, nFe0 = 0, nCv1 = 0, nFd1 = 0;

    logic [39:0] rxA, rxB, rxOe;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cv0) nCv0++;
        if (fd0) nFd0++;
        if (fe0) nFe0++;
        if (cv1) nCv1++;
        if (fd1) nFd1++;
    end

    ad7264_spi_responder dut0 (
        .clk(clk), .resetn(resetn), .SCLK(sclk0), .SS(ss0), .MOSI(mosi),
        .MISO_A(misoA0), .MISO_B(misoB0), .miso_oe(oe0),
        .sampleA(sampleA), .sampleB(sampleB), .ctrl_word(cw0),
        .ctrl_valid(cv0), .frame_done(fd0), .frame_error(fe0), .busy(busy0)
    );

    ad7264_spi_responder #(.CPOL(1'b0), .CPHA(1'b1)) dut1 (
        .clk(clk), .resetn(resetn), .SCLK(sclk1), .SS(ss1), .MOSI(mosi),
        .MISO_A(misoA1), .MISO_B(misoB1), .miso_oe(oe1),
        .sampleA(sampleA), .sampleB(sampleB), .ctrl_word(cw1),
        .ctrl_valid(cv1), .frame_done(fd1), .frame_error(fe1), .busy(busy1)
    );

    task automatic setSclk(input int sel, input logic v);
        if (sel == 0) sclk0 = v; else sclk1 = v;
    endtask

    task automatic setSs(input int sel, input logic v);
        if (sel == 0) ss0 = v; else ss1 = v;
    endtask

    task automatic capture(input int sel);
        if (sel == 0) begin
            rxA = {rxA[38:0], misoA0}; rxB = {rxB[38:0], misoB0}; rxOe = {rxOe[38:0], oe0};
        end else begin
            rxA = {rxA[38:0], misoA1}; rxB = {rxB[38:0], misoB1}; rxOe = {rxOe[38:0], oe1};
        end
    endtask

    // Mode-matched master. sel 0 = CPOL1/CPHA0, sel 1 = CPOL0/CPHA1.
    // Half SCLK period is 40 ns (8 clk per SCLK period).
    task automatic runFrame(input int sel, input logic [15:0] ctrl, input int nEdges,
                            input bit raiseSs, input int chgEdge, input logic [13:0] chgVal);
        logic cpol, cpha;
        cpol = (sel == 0);
        cpha = (sel == 1);
        rxA = '0; rxB = '0; rxOe = '0;
        mosi = cpha ? 1'b0 : ctrl[15];
        setSs(sel, 1'b0);
        #80;
        for (int k = 0; k < nEdges; k++) begin
            if (k == chgEdge) sampleA = chgVal;
            if (!cpha) capture(sel);
            setSclk(sel, ~cpol);
            if (cpha) begin
                if (k < 16) mosi = ctrl[15-k]; else mosi = 1'b0;
            end
            #40;
            if (cpha) capture(sel);
            setSclk(sel, cpol);
            if (!cpha) begin
                if (k < 15) mosi = ctrl[14-k]; else mosi = 1'b0;
            end
            #40;
        end
        #40;
        if (raiseSs) begin
            setSs(sel, 1'b1);
            #80;
        end
    endtask

    task automatic test_reset;
        nChecks++; if (cw0 !== 16'h0000) begin nFail++; $display("FAIL reset_ctrl_word: got %h expected 0000", cw0); end
        nChecks++; if (cw1 !== 16'h0000) begin nFail++; $display("FAIL reset_ctrl_word_m1: got %h expected 0000", cw1); end
        nChecks++; if ({misoA0, misoB0, oe0, cv0, fd0, fe0, busy0} !== 7'b0) begin
            nFail++; $display("FAIL reset_outputs: got %b expected 0000000", {misoA0, misoB0, oe0, cv0, fd0, fe0, busy0}); end
    endtask

    task automatic test_frame;
        int cvB, fdB, feB;
        cvB = nCv0; fdB = nFd0; feB = nFe0;
        sampleA = 14'h2ABC; sampleB = 14'h1234;
        runFrame(0, 16'hA5C3, 32, 1'b0, -1, 14'h0);
        nChecks++; if (cw0 !== 16'hA5C3) begin nFail++; $display("FAIL frame_ctrl_word: got %h expected a5c3", cw0); end
        nChecks++; if (nCv0 - cvB !== 1) begin nFail++; $display("FAIL frame_ctrl_valid_count: got %0d expected 1", nCv0 - cvB); end
        nChecks++; if (rxA[31:0] !== 32'h0000_2ABC) begin nFail++; $display("FAIL frame_miso_a: got %h expected 00002abc", rxA[31:0]); end
        nChecks++; if (rxB[31:0] !== 32'h0000_1234) begin nFail++; $display("FAIL frame_miso_b: got %h expected 00001234", rxB[31:0]); end
        nChecks++; if (nFd0 - fdB !== 1) begin nFail++; $display("FAIL frame_done_count: got %0d expected 1", nFd0 - fdB); end
        nChecks++; if ({busy0, oe0} !== 2'b10) begin nFail++; $display("FAIL frame_done_state busy/oe: got %b expected 10", {busy0, oe0}); end
        ss0 = 1'b1;
        #80;
        nChecks++; if (busy0 !== 1'b0) begin nFail++; $display("FAIL frame_release_busy: got %b expected 0", busy0); end
        nChecks++; if (nFe0 - feB !== 0) begin nFail++; $display("FAIL frame_no_error: got %0d expected 0", nFe0 - feB); end
    endtask

    task automatic test_abort;
        int cvB, feB;
        cvB = nCv0; feB = nFe0;
        runFrame(0, 16'h1111, 10, 1'b1, -1, 14'h0);
        nChecks++; if (nFe0 - feB !== 1) begin nFail++; $display("FAIL abort_frame_error: got %0d expected 1", nFe0 - feB); end
        nChecks++; if (cw0 !== 16'hA5C3) begin nFail++; $display("FAIL abort_ctrl_word: got %h expected a5c3", cw0); end
        nChecks++; if (nCv0 - cvB !== 0) begin nFail++; $display("FAIL abort_ctrl_valid: got %0d expected 0", nCv0 - cvB); end
        nChecks++; if ({busy0, oe0} !== 2'b00) begin nFail++; $display("FAIL abort_idle busy/oe: got %b expected 00", {busy0, oe0}); end
    endtask

    task automatic test_back_to_back;
        int fdB;
        fdB = nFd0;
        sampleA = 14'h0001; sampleB = 14'h0000;
        runFrame(0, 16'h0F0F, 32, 1'b1, 5, 14'h3FFF);
        nChecks++; if (rxA[31:0] !== 32'h0000_0001) begin nFail++; $display("FAIL b2b_frame1_a: got %h expected 00000001", rxA[31:0]); end
        nChecks++; if (cw0 !== 16'h0F0F) begin nFail++; $display("FAIL b2b_frame1_ctrl: got %h expected 0f0f", cw0); end
        runFrame(0, 16'hF0F0, 32, 1'b1, -1, 14'h0);
        nChecks++; if (rxA[31:0] !== 32'h0000_3FFF) begin nFail++; $display("FAIL b2b_frame2_a: got %h expected 00003fff", rxA[31:0]); end
        nChecks++; if (cw0 !== 16'hF0F0) begin nFail++; $display("FAIL b2b_frame2_ctrl: got %h expected f0f0", cw0); end
        nChecks++; if (nFd0 - fdB !== 2) begin nFail++; $display("FAIL b2b_done_count: got %0d expected 2", nFd0 - fdB); end
    endtask

    task automatic test_overrun;
        int fdB;
        fdB = nFd0;
        sampleA = 14'h155A; sampleB = 14'h2AA5;
        runFrame(0, 16'h1234, 40, 1'b0, -1, 14'h0);
        nChecks++; if (nFd0 - fdB !== 1) begin nFail++; $display("FAIL overrun_done_count: got %0d expected 1", nFd0 - fdB); end
        nChecks++; if (rxA !== 40'h00_0015_5A00) begin nFail++; $display("FAIL overrun_miso_a: got %h expected 0000155a00", rxA); end
        nChecks++; if (rxB !== 40'h00_002A_A500) begin nFail++; $display("FAIL overrun_miso_b: got %h expected 00002aa500", rxB); end
        nChecks++; if (rxOe !== 40'hFF_FFFF_FF00) begin nFail++; $display("FAIL overrun_oe: got %h expected ffffffff00", rxOe); end
        nChecks++; if (cw0 !== 16'h1234) begin nFail++; $display("FAIL overrun_ctrl: got %h expected 1234", cw0); end
        ss0 = 1'b1;
        #80;
    endtask

    task automatic test_mode1;
        int cvB, fdB;
        cvB = nCv1; fdB = nFd1;
        sampleA = 14'h2ABC; sampleB = 14'h1234;
        runFrame(1, 16'hA5C3, 32, 1'b1, -1, 14'h0);
        nChecks++; if (cw1 !== 16'hA5C3) begin nFail++; $display("FAIL mode1_ctrl_word: got %h expected a5c3", cw1); end
        nChecks++; if (rxA[31:0] !== 32'h0000_2ABC) begin nFail++; $display("FAIL mode1_miso_a: got %h expected 00002abc", rxA[31:0]); end
        nChecks++; if (rxB[31:0] !== 32'h0000_1234) begin nFail++; $display("FAIL mode1_miso_b: got %h expected 00001234", rxB[31:0]); end
        nChecks++; if (nCv1 - cvB !== 1) begin nFail++; $display("FAIL mode1_ctrl_valid: got %0d expected 1", nCv1 - cvB); end
        nChecks++; if (nFd1 - fdB !== 1) begin nFail++; $display("FAIL mode1_done_count: got %0d expected 1", nFd1 - fdB); end
    endtask

    task automatic test_reset_mid;
        int fdB;
        sampleA = 14'h2ABC; sampleB = 14'h1234;
        runFrame(0, 16'h5A5A, 20, 1'b0, -1, 14'h0);
        resetn = 1'b0;
        #1;
        nChecks++; if (cw0 !== 16'h0000) begin nFail++; $display("FAIL rstmid_ctrl_word: got %h expected 0000", cw0); end
        nChecks++; if ({misoA0, misoB0, oe0, cv0, fd0, fe0, busy0} !== 7'b0) begin
            nFail++; $display("FAIL rstmid_outputs: got %b expected 0000000", {misoA0, misoB0, oe0, cv0, fd0, fe0, busy0}); end
        #19;
        ss0 = 1'b1;
        #20;
        resetn = 1'b1;
        #40;
        fdB = nFd0;
        runFrame(0, 16'h3C96, 32, 1'b1, -1, 14'h0);
        nChecks++; if (cw0 !== 16'h3C96) begin nFail++; $display("FAIL rstmid_next_ctrl: got %h expected 3c96", cw0); end
        nChecks++; if (rxA[31:0] !== 32'h0000_2ABC) begin nFail++; $display("FAIL rstmid_next_a: got %h expected 00002abc", rxA[31:0]); end
        nChecks++; if (rxB[31:0] !== 32'h0000_1234) begin nFail++; $display("FAIL rstmid_next_b: got %h expected 00001234", rxB[31:0]); end
        nChecks++; if (nFd0 - fdB !== 1) begin nFail++; $display("FAIL rstmid_next_done: got %0d expected 1", nFd0 - fdB); end
    endtask

    initial begin
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        test_reset;
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        test_frame;
        test_abort;
        test_back_to_back;
        test_overrun;
        test_mode1;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
`default_nettype wire
